// File: rtl/arb_mux_stream_if.sv
// Stream bundle between N source channels and one downstream consumer.
// The arbiter takes the slave view; the environment drives through the master view.
interface arb_mux_stream_if #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2
);
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SEL_W-1:0] out_sel;
  logic           out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/arb_mux_stream.sv
// N-to-1 valid/ready arbiter-multiplexer with a registered output stage,
// fixed-priority or round-robin grant, and optional packet locking.
module arb_mux_stream #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int MODE  = 0,
  parameter int LOCK  = 0,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  arb_mux_stream_if.slave bus
);
  logic             out_valid_reg;
  logic [W-1:0]     out_data_reg;
  logic             out_last_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic [SEL_W-1:0] rr_ptr_reg;
  logic             lock_active_reg;
  logic [SEL_W-1:0] lock_ch_reg;

  logic             load_en;
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] rr_ptr_next;
  logic             accept;
  logic [W-1:0]     grant_data;
  logic             grant_last;

  assign load_en = !out_valid_reg || bus.out_ready;

  // Search runs highest offset first so the lowest offset from the start point wins.
  always_comb begin
    int start;
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    start     = (MODE == 1) ? int'(rr_ptr_reg) : 0;
    idx       = 0;
    if (lock_active_reg) begin
      grant_any = bus.in_valid[lock_ch_reg];
      grant_idx = lock_ch_reg;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = start + k;
        if (idx >= N) idx = idx - N;
        if (bus.in_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  assign accept      = !rst && load_en && grant_any;
  assign grant_data  = bus.in_data[grant_idx*W +: W];
  assign grant_last  = bus.in_last[grant_idx];
  assign rr_ptr_next = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign bus.in_ready[gi] = accept && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_last_reg    <= 1'b0;
      out_sel_reg     <= '0;
      rr_ptr_reg      <= '0;
      lock_active_reg <= 1'b0;
      lock_ch_reg     <= '0;
    end else if (load_en) begin
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= grant_data;
        out_last_reg  <= grant_last;
        out_sel_reg   <= grant_idx;
        // With locking the pointer advances once per packet, on its final beat.
        if (MODE == 1 && (LOCK == 0 || grant_last)) begin
          rr_ptr_reg <= rr_ptr_next;
        end
        if (LOCK == 1) begin
          lock_active_reg <= !grant_last;
          lock_ch_reg     <= grant_idx;
        end
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_sel   = out_sel_reg;
endmodule

// File: tb/tb_arb_mux_stream.sv
// Drives four arbiter configurations with one shared stimulus stream and
// compares each against a behavioural model of the grant/output rules.
module tb_arb_mux_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_mux_stream_if #(.N(4), .W(8), .SEL_W(2)) if0 ();
  arb_mux_stream_if #(.N(4), .W(8), .SEL_W(2)) if1 ();
  arb_mux_stream_if #(.N(4), .W(8), .SEL_W(2)) if2 ();
  arb_mux_stream_if #(.N(3), .W(8), .SEL_W(2)) if3 ();

  arb_mux_stream #(.N(4), .W(8), .MODE(0), .LOCK(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  arb_mux_stream #(.N(4), .W(8), .MODE(1), .LOCK(0)) u1 (.clk(clk), .rst(rst), .bus(if1));
  arb_mux_stream #(.N(4), .W(8), .MODE(0), .LOCK(1)) u2 (.clk(clk), .rst(rst), .bus(if2));
  arb_mux_stream #(.N(3), .W(8), .MODE(1), .LOCK(1)) u3 (.clk(clk), .rst(rst), .bus(if3));

  logic [3:0] rdy_o[4];
  logic       ov_o[4];
  logic [7:0] od_o[4];
  logic       ol_o[4];
  logic [1:0] os_o[4];

  assign rdy_o[0] = if0.in_ready;
  assign rdy_o[1] = if1.in_ready;
  assign rdy_o[2] = if2.in_ready;
  assign rdy_o[3] = {1'b0, if3.in_ready};
  assign ov_o[0] = if0.out_valid; assign od_o[0] = if0.out_data; assign ol_o[0] = if0.out_last; assign os_o[0] = if0.out_sel;
  assign ov_o[1] = if1.out_valid; assign od_o[1] = if1.out_data; assign ol_o[1] = if1.out_last; assign os_o[1] = if1.out_sel;
  assign ov_o[2] = if2.out_valid; assign od_o[2] = if2.out_data; assign ol_o[2] = if2.out_last; assign os_o[2] = if2.out_sel;
  assign ov_o[3] = if3.out_valid; assign od_o[3] = if3.out_data; assign ol_o[3] = if3.out_last; assign os_o[3] = if3.out_sel;

  // Configuration of each instance, as seen by the model.
  int nn[4]   = '{4, 4, 4, 3};
  int mode[4] = '{0, 1, 0, 1};
  int lck[4]  = '{0, 0, 1, 1};

  // Stimulus shared by all instances (instance 3 sees only channels 0..2).
  logic [3:0] v;
  logic [3:0] l;
  logic [7:0] d[4];
  logic       ordy;

  // Model state per instance.
  int         m_ov[4];
  logic [7:0] m_od[4];
  int         m_ol[4];
  int         m_os[4];
  int         m_rr[4];
  int         m_la[4];
  int         m_lc[4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] cycle %0d observed=%0h expected=%0h", tag, inst, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ov[i] = 0; m_od[i] = 8'h00; m_ol[i] = 0; m_os[i] = 0;
      m_rr[i] = 0; m_la[i] = 0;     m_lc[i] = 0;
    end
  endtask

  // Which channel the rules say is granted this cycle, or -1 for none.
  function automatic int model_grant(input int i);
    int start;
    int c;
    if (rst) return -1;
    if (m_ov[i] != 0 && !ordy) return -1;
    if (m_la[i] != 0) return v[m_lc[i]] ? m_lc[i] : -1;
    start = (mode[i] == 1) ? m_rr[i] : 0;
    for (int k = 0; k < nn[i]; k++) begin
      c = (start + k) % nn[i];
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    if0.in_valid = v;      if0.in_last = l;      if0.in_data = {d[3], d[2], d[1], d[0]}; if0.out_ready = ordy;
    if1.in_valid = v;      if1.in_last = l;      if1.in_data = {d[3], d[2], d[1], d[0]}; if1.out_ready = ordy;
    if2.in_valid = v;      if2.in_last = l;      if2.in_data = {d[3], d[2], d[1], d[0]}; if2.out_ready = ordy;
    if3.in_valid = v[2:0]; if3.in_last = l[2:0]; if3.in_data = {d[2], d[1], d[0]};       if3.out_ready = ordy;
  endtask

  // One clock: drive, check grants mid-cycle, clock the model, check outputs.
  task automatic cycle();
    int g[4];
    drive();
    #4;
    for (int i = 0; i < 4; i++) begin
      g[i] = model_grant(i);
      chk("in_ready", i, 32'(rdy_o[i]), (g[i] < 0) ? 32'd0 : (32'd1 << g[i]));
    end
    $display("cyc %0d rst=%0b v=%b l=%b ordy=%0b rdy=%h/%h/%h/%h", cyc, rst, v, l, ordy,
             rdy_o[0], rdy_o[1], rdy_o[2], rdy_o[3]);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_ov[i] == 0 || ordy) begin
          if (g[i] >= 0) begin
            m_ov[i] = 1;
            m_od[i] = d[g[i]];
            m_ol[i] = int'(l[g[i]]);
            m_os[i] = g[i];
            if (mode[i] == 1 && (lck[i] == 0 || l[g[i]])) m_rr[i] = (g[i] + 1) % nn[i];
            if (lck[i] == 1) begin
              if (l[g[i]]) m_la[i] = 0;
              else begin m_la[i] = 1; m_lc[i] = g[i]; end
            end
          end else begin
            m_ov[i] = 0;
          end
        end
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("out_valid", i, 32'(ov_o[i]), 32'(m_ov[i]));
      chk("out_data",  i, 32'(od_o[i]), 32'(m_od[i]));
      chk("out_last",  i, 32'(ol_o[i]), 32'(m_ol[i]));
      chk("out_sel",   i, 32'(os_o[i]), 32'(m_os[i]));
    end
    cyc++;
  endtask

  task automatic set(input logic [3:0] nv, input logic [3:0] nl, input logic nr);
    v = nv; l = nl; ordy = nr;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    set(4'b1111, 4'b0000, 1'b1);
    d[0] = 8'h10; d[1] = 8'h11; d[2] = 8'h12; d[3] = 8'h13;
    @(posedge clk); #1;

    // Reset with sources active: no grants, outputs cleared.
    cycle();
    rst = 1'b0;

    // All channels valid, single-beat packets: fixed priority vs rotation.
    set(4'b1111, 4'b1111, 1'b1);
    for (int k = 0; k < 6; k++) cycle();

    // Drain, then a single beat on ch2 held under backpressure.
    set(4'b0000, 4'b1111, 1'b1); cycle();
    d[2] = 8'hA5;
    set(4'b0100, 4'b1111, 1'b0); cycle();
    set(4'b0100, 4'b1111, 1'b0); for (int k = 0; k < 3; k++) cycle();
    set(4'b0000, 4'b1111, 1'b1); cycle();
    cycle();

    // Three-beat packet on ch3; ch0 arrives after the first beat.
    d[3] = 8'h31; set(4'b1000, 4'b0000, 1'b1); cycle();
    d[3] = 8'h32; set(4'b1001, 4'b0000, 1'b1); cycle();
    d[3] = 8'h33; set(4'b1001, 4'b1000, 1'b1); cycle();
    set(4'b0001, 4'b1111, 1'b1); cycle();
    set(4'b0000, 4'b1111, 1'b1); cycle();

    // Round-robin wrap on the three-channel instance.
    set(4'b0100, 4'b1111, 1'b1); cycle();
    set(4'b0101, 4'b1111, 1'b1); cycle();
    cycle();

    // Reset in the middle of a locked packet.
    set(4'b1000, 4'b0000, 1'b1); cycle();
    set(4'b0100, 4'b0000, 1'b0); cycle();
    rst = 1'b1; set(4'b1111, 4'b0000, 1'b1); cycle();
    rst = 1'b0; set(4'b1111, 4'b1111, 1'b1); cycle();
    cycle();

    // Random traffic with occasional resets and backpressure.
    for (int k = 0; k < 500; k++) begin
      v    = 4'($urandom);
      l    = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < 4; c++) d[c] = 8'($urandom);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arb_mux_stream.md
Name: arb_mux_stream

Overview:
Parametrised N-to-1 streaming multiplexer. It replaces fixed 4:1 select-driven muxing with internal arbitration between N valid/ready source channels. A registered output stage feeds one downstream consumer. Selectable fixed-priority or round-robin arbitration, with optional packet locking so that multi-beat transfers are never interleaved.

Parameters:
N, 4, number of input channels (2..16)
W, 8, data width per channel
MODE, 0, 0 = fixed priority (channel 0 highest), 1 = round-robin
LOCK, 0, 1 = grant held on one channel until its in_last beat is accepted
SEL_W, $clog2(N), width of out_sel (derived, minimum 1)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  N  per-channel valid
in_data  in  N*W  channel i occupies bits [i*W +: W]
in_last  in  N  per-channel end-of-packet marker (ignored when LOCK=0)
in_ready  out  N  per-channel accept; at most one bit set per cycle
out_valid  out  1  output register holds a beat
out_data  out  W  registered data
out_last  out  1  registered in_last of the beat
out_sel  out  SEL_W  index of the channel the beat came from
out_ready  in  1  downstream accept

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_last=0, out_sel=0, rr_ptr=0, lock_active=0, lock_ch=0. While rst=1, in_ready=0 (combinational gating).
- load_en = !out_valid || out_ready. This is the output register's free/draining condition and allows full throughput (1 beat/cycle).
- Grant (combinational): only evaluated when load_en=1; otherwise in_ready=0.
  - If lock_active: candidate is lock_ch only; no grant if in_valid[lock_ch]=0 (other channels stall).
  - MODE=0: lowest-index i with in_valid[i]=1.
  - MODE=1: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... wrapping modulo N.
  - in_ready[g]=1 for granted g only; no valid input → in_ready all 0.
- Transfer: input beat accepted when in_valid[g] && in_ready[g]. At that edge out_data, out_last, and out_sel are loaded with channel g's data, last and index, and out_valid<=1.
- If load_en && no grant: out_valid<=0 (previous beat drained by out_ready).
- Output stable while out_valid && !out_ready: out_* must not change.
- Latency: accepted beat appears on out_* the next cycle.
- Round-robin pointer (MODE=1): on each accepted beat, rr_ptr <= (g+1) mod N. With LOCK=1, it updates only on the beat that ends the packet (in_last=1), so the pointer moves once per packet. N non-power-of-2 wraps at N-1 → 0.
- Lock (LOCK=1):
  - Accepted beat with in_last=0 → lock_active<=1, lock_ch<=g.
  - Accepted beat with in_last=1 → lock_active<=0.
  - A single-beat packet (in_last=1 on the first beat) never locks.
- LOCK=0: in_last is passed through to out_last; lock state remains 0.
- Simultaneous events: drain and new accept in the same cycle are allowed (out_valid stays 1, new data loaded).
- Reset mid-packet: lock is cleared, any held output beat is discarded; no recovery of partial packet.
- in_valid may deassert without a transfer. The block does not require source stability for correctness; grant is recomputed every cycle.

Test Plan:
- MODE=0, N=4, all in_valid=1 with data 0x10,0x11,0x12,0x13, out_ready=1 → out_data 0x10 every cycle; in_ready=4'b0001; out_sel=0.
- MODE=1, N=4, all valid continuously, out_ready=1 → out_sel sequence 0,1,2,3,0,1 one per cycle; each in_ready one-hot in the same order.
- Backpressure: single beat 0xA5 on ch2, out_ready=0 for 3 cycles → out_valid=1, out_data=0xA5 and out_sel=2 held stable; in_ready=0 throughout; beat drains when out_ready=1.
- LOCK=1, MODE=0: ch3 sends 3-beat packet (last on beat 3), ch0 raises valid after beat 1 → ch0 not granted until ch3 beat 3 is accepted; out_sel=3,3,3,0.
- N=3, MODE=1: rr_ptr wraps 2→0; with ch0 and ch2 valid after a ch2 grant → next grant ch0.
- rst asserted while out_valid=1 and lock_active=1 → next cycle out_valid=0, in_ready=0 during rst, first post-reset grant from ch0 (rr_ptr=0).
